// File: rtl/core_run_ctrl.sv
// core_run_ctrl
// Run/load controller for the single-cycle core.
//
// The host loads a program into the icache through this block, one word per
// valid/ready handshake. Once a program is loaded, the block sequences
// execution by gating PC advance and register-file writes. It supports free
// run, single-step, halt and a single hardware breakpoint. It also counts
// retired instructions.
//
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   load_start_i          begin a program load (honoured in IDLE/HALT)
//   load_len_i            number of words to load, legal range 1..DEPTH
//   ld_data_i/ld_valid_i  host word and its valid strobe
//   ld_ready_o            controller accepts a word (LOAD state)
//   imem_we_o/waddr_o/wdata_o   icache write port
//   run_i/step_i/halt_i   execution commands
//   bkpt_en_i/bkpt_addr_i breakpoint enable and byte address
//   pc_i                  current PC from the datapath
//   pc_en_o               PC loads pcnext this cycle
//   pc_rst_o              force PC to 0
//   regwrite_en_o         AND-gate on the decoder regwrite
//   bkpt_hit_o            sticky flag: last stop was a breakpoint
//   state_o               encoded controller state
//   retired_o             retired-instruction count (wraps)
module core_run_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
    input  logic [ADDR_W:0]   load_len_i,
    input  logic [31:0]       ld_data_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_waddr_o,
    output logic [31:0]       imem_wdata_o,
    input  logic              run_i,
    input  logic              step_i,
    input  logic              halt_i,
    input  logic              bkpt_en_i,
    input  logic [31:0]       bkpt_addr_i,
    input  logic [31:0]       pc_i,
    output logic              pc_en_o,
    output logic              pc_rst_o,
    output logic              regwrite_en_o,
    output logic              bkpt_hit_o,
    output logic [2:0]        state_o,
    output logic [31:0]       retired_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLEAR = 3'd2,
        HALT  = 3'd3,
        RUN   = 3'd4,
        STEP  = 3'd5
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W:0]   load_len;
    logic [ADDR_W-1:0] load_cnt;
    logic [31:0]       retired;
    logic              bkpt_hit;
    logic              skip;

    logic len_legal;
    logic bkpt_match;
    logic load_last;
    logic start_load;
    logic load_accept;
    logic retire;
    logic clr_retired;
    logic set_hit;
    logic clr_hit;
    logic set_skip;

    assign len_legal  = (load_len_i != '0) && (load_len_i <= (ADDR_W+1)'(DEPTH));
    // The skip flag masks the breakpoint on the first RUN cycle after a
    // resume. Without it, a resume at the breakpoint PC would stop again
    // immediately.
    assign bkpt_match = bkpt_en_i && (pc_i == bkpt_addr_i) && !skip;
    assign load_last  = ({1'b0, load_cnt} == (load_len - (ADDR_W+1)'(1)));

    always_comb begin
        state_next    = state;
        ld_ready_o    = 1'b0;
        imem_we_o     = 1'b0;
        imem_waddr_o  = '0;
        pc_en_o       = 1'b0;
        pc_rst_o      = 1'b0;
        regwrite_en_o = 1'b0;
        start_load    = 1'b0;
        load_accept   = 1'b0;
        retire        = 1'b0;
        clr_retired   = 1'b0;
        set_hit       = 1'b0;
        clr_hit       = 1'b0;
        set_skip      = 1'b0;
        case (state)
            IDLE: begin
                pc_rst_o = 1'b1;
                if (load_start_i && len_legal) begin
                    start_load = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                ld_ready_o   = 1'b1;
                imem_we_o    = ld_valid_i;
                imem_waddr_o = load_cnt;
                load_accept  = ld_valid_i;
                if (ld_valid_i && load_last) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                pc_rst_o    = 1'b1;
                clr_retired = 1'b1;
                clr_hit     = 1'b1;
                state_next  = HALT;
            end
            HALT: begin
                // An illegal load request is treated as absent. A step or
                // run in the same cycle can still take effect.
                if (load_start_i && len_legal) begin
                    start_load = 1'b1;
                    clr_hit    = 1'b1;
                    state_next = LOAD;
                end else if (step_i) begin
                    clr_hit    = 1'b1;
                    state_next = STEP;
                end else if (run_i) begin
                    clr_hit    = 1'b1;
                    set_skip   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // A breakpoint stops before the instruction executes. A halt
                // lets the current instruction retire first.
                if (bkpt_match) begin
                    set_hit    = 1'b1;
                    state_next = HALT;
                end else begin
                    pc_en_o       = 1'b1;
                    regwrite_en_o = 1'b1;
                    retire        = 1'b1;
                    if (halt_i) begin
                        state_next = HALT;
                    end
                end
            end
            STEP: begin
                pc_en_o       = 1'b1;
                regwrite_en_o = 1'b1;
                retire        = 1'b1;
                state_next    = HALT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            load_len <= '0;
            load_cnt <= '0;
            retired  <= '0;
            bkpt_hit <= 1'b0;
            skip     <= 1'b0;
        end else begin
            state <= state_next;

            if (start_load) begin
                load_len <= load_len_i;
                load_cnt <= '0;
            end else if (load_accept) begin
                load_cnt <= load_cnt + ADDR_W'(1);
            end

            if (clr_retired) begin
                retired <= '0;
            end else if (retire) begin
                retired <= retired + 32'd1;
            end

            if (set_hit) begin
                bkpt_hit <= 1'b1;
            end else if (clr_hit) begin
                bkpt_hit <= 1'b0;
            end

            if (set_skip) begin
                skip <= 1'b1;
            end else if (state == RUN) begin
                skip <= 1'b0;
            end
        end
    end

    assign imem_wdata_o = ld_data_i;
    assign bkpt_hit_o   = bkpt_hit;
    assign state_o      = state;
    assign retired_o    = retired;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl
// Directed, table-driven bench for core_run_ctrl.
//
// Each table row holds the inputs for one clock cycle and the outputs
// expected in that cycle, before the next rising edge. The outputs reflect
// the state registered at the previous edge together with the current inputs.
// A hand-written sequence then covers a reset that arrives in the middle of
// a load.
module tb_core_run_ctrl;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              load_start_i;
    logic [ADDR_W:0]   load_len_i;
    logic [31:0]       ld_data_i;
    logic              ld_valid_i;
    logic              ld_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_waddr_o;
    logic [31:0]       imem_wdata_o;
    logic              run_i;
    logic              step_i;
    logic              halt_i;
    logic              bkpt_en_i;
    logic [31:0]       bkpt_addr_i;
    logic [31:0]       pc_i;
    logic              pc_en_o;
    logic              pc_rst_o;
    logic              regwrite_en_o;
    logic              bkpt_hit_o;
    logic [2:0]        state_o;
    logic [31:0]       retired_o;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic              rst;
        logic              ls;
        logic [ADDR_W:0]   len;
        logic              vld;
        logic [31:0]       data;
        logic              run;
        logic              step;
        logic              halt;
        logic              ben;
        logic [31:0]       pc;
        logic [2:0]        st;
        logic              rdy;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic              pen;
        logic              prst;
        logic              rw;
        logic              hit;
        logic [31:0]       ret;
    } vec_t;

    vec_t vecs[$];

    core_run_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .load_start_i(load_start_i), .load_len_i(load_len_i),
        .ld_data_i(ld_data_i), .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
        .imem_we_o(imem_we_o), .imem_waddr_o(imem_waddr_o), .imem_wdata_o(imem_wdata_o),
        .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
        .bkpt_en_i(bkpt_en_i), .bkpt_addr_i(bkpt_addr_i), .pc_i(pc_i),
        .pc_en_o(pc_en_o), .pc_rst_o(pc_rst_o), .regwrite_en_o(regwrite_en_o),
        .bkpt_hit_o(bkpt_hit_o), .state_o(state_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input int rst, input int ls, input int len, input int vld,
                                input logic [31:0] data, input int run, input int step,
                                input int halt, input int ben, input logic [31:0] pc,
                                input int st, input int rdy, input int we, input int wa,
                                input int pen, input int prst, input int rw, input int hit,
                                input logic [31:0] ret);
        vec_t v;
        v.rst = rst[0];   v.ls = ls[0];     v.len = len[ADDR_W:0]; v.vld = vld[0];
        v.data = data;    v.run = run[0];   v.step = step[0];      v.halt = halt[0];
        v.ben = ben[0];   v.pc = pc;        v.st = st[2:0];        v.rdy = rdy[0];
        v.we = we[0];     v.wa = wa[ADDR_W-1:0]; v.pen = pen[0];   v.prst = prst[0];
        v.rw = rw[0];     v.hit = hit[0];   v.ret = ret;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        rst_i        = v.rst;
        load_start_i = v.ls;
        load_len_i   = v.len;
        ld_valid_i   = v.vld;
        ld_data_i    = v.data;
        run_i        = v.run;
        step_i       = v.step;
        halt_i       = v.halt;
        bkpt_en_i    = v.ben;
        pc_i         = v.pc;
    endtask

    task automatic check_field(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_output(input vec_t v, input int idx);
        check_field("state_o",       idx, 32'(state_o),       32'(v.st));
        check_field("ld_ready_o",    idx, 32'(ld_ready_o),    32'(v.rdy));
        check_field("imem_we_o",     idx, 32'(imem_we_o),     32'(v.we));
        check_field("imem_waddr_o",  idx, 32'(imem_waddr_o),  32'(v.wa));
        check_field("pc_en_o",       idx, 32'(pc_en_o),       32'(v.pen));
        check_field("pc_rst_o",      idx, 32'(pc_rst_o),      32'(v.prst));
        check_field("regwrite_en_o", idx, 32'(regwrite_en_o), 32'(v.rw));
        check_field("bkpt_hit_o",    idx, 32'(bkpt_hit_o),    32'(v.hit));
        check_field("retired_o",     idx, retired_o,          v.ret);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //          rst ls len vld data          run stp hlt ben pc        st rdy we wa pen prst rw hit ret
        // reset state, then load 3 words with valid every cycle
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3,  0, 32'h0,        0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  1, 32'h00500093, 0, 0, 0, 0, 32'h0,    1, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  1, 32'h00308113, 0, 0, 0, 0, 32'h0,    1, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  1, 32'h002081B3, 0, 0, 0, 0, 32'h0,    1, 1, 1, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    2, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 0));
        // reload from HALT with valid toggling 1,0,1,0,1
        vecs.push_back(mk(0, 1, 3,  0, 32'h0,        0, 0, 0, 0, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  1, 32'h11,       0, 0, 0, 0, 32'h0,    1, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    1, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  1, 32'h22,       0, 0, 0, 0, 32'h0,    1, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    1, 1, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  1, 32'h33,       0, 0, 0, 0, 32'h0,    1, 1, 1, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    2, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 0));
        // back to IDLE: illegal lengths 0 and 65, run/step ignored
        vecs.push_back(mk(1, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 65, 0, 32'h0,        0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        1, 1, 0, 0, 32'h0,    0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 1, 0, 0, 0));
        // single-word load (length 1 boundary)
        vecs.push_back(mk(0, 1, 1,  0, 32'h0,        0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  1, 32'h44,       0, 0, 0, 0, 32'h0,    1, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    2, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 0));
        // three single steps
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 1, 0, 0, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    5, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 1, 0, 0, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    5, 0, 0, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 1, 0, 0, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    5, 0, 0, 0, 1, 0, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 3));
        // reload to clear retired count
        vecs.push_back(mk(0, 1, 1,  0, 32'h0,        0, 0, 0, 0, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0,  1, 32'h55,       0, 0, 0, 0, 32'h0,    1, 1, 1, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    2, 0, 0, 0, 0, 1, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 0));
        // run into breakpoint at 0x8, then resume over it
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        1, 0, 0, 1, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 1, 32'h0,    4, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 1, 32'h4,    4, 0, 0, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 1, 32'h8,    4, 0, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 1, 32'h8,    3, 0, 0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        1, 0, 0, 1, 32'h8,    3, 0, 0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 1, 32'h8,    4, 0, 0, 0, 1, 0, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 1, 32'hC,    4, 0, 0, 0, 1, 0, 1, 0, 3));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 1, 32'h10,   4, 0, 0, 0, 1, 0, 1, 0, 4));
        // halt_i at retired=5: that instruction still retires
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 1, 1, 32'h14,   4, 0, 0, 0, 1, 0, 1, 0, 5));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 1, 32'h18,   3, 0, 0, 0, 0, 0, 0, 0, 6));
        // halt_i together with breakpoint: breakpoint wins, no retire
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        1, 0, 0, 1, 32'h18,   3, 0, 0, 0, 0, 0, 0, 0, 6));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 1, 32'h18,   4, 0, 0, 0, 1, 0, 1, 0, 6));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 1, 1, 32'h8,    4, 0, 0, 0, 0, 0, 0, 0, 7));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 1, 32'h8,    3, 0, 0, 0, 0, 0, 0, 1, 7));
        // step executes even at the breakpoint address
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 1, 0, 1, 32'h8,    3, 0, 0, 0, 0, 0, 0, 1, 7));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 1, 32'h8,    5, 0, 0, 0, 1, 0, 1, 0, 7));
        vecs.push_back(mk(0, 0, 0,  0, 32'h0,        0, 0, 0, 0, 32'h0,    3, 0, 0, 0, 0, 0, 0, 0, 8));

        bkpt_addr_i = 32'h8;
        apply_stimulus(vecs[0]);
        repeat (2) @(posedge clk_i);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output(vecs[i], i);
            tick();
        end

        // Reset arriving after the first word of a load
        $display("[TB] reset during load sequence");
        apply_stimulus(mk(0, 1, 3, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        ld_valid_i   = 1'b1;
        load_start_i = 1'b0;
        ld_data_i    = 32'hDEADBEEF;
        #1;
        check_field("mid_load_we",    100, 32'(imem_we_o),    32'd1);
        check_field("mid_load_wdata", 100, imem_wdata_o,      32'hDEADBEEF);
        check_field("mid_load_state", 100, 32'(state_o),      32'd1);
        tick();
        ld_valid_i = 1'b0;
        rst_i      = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        check_field("rst_state",   101, 32'(state_o),    32'd0);
        check_field("rst_pc_rst",  101, 32'(pc_rst_o),   32'd1);
        check_field("rst_ready",   101, 32'(ld_ready_o), 32'd0);
        check_field("rst_retired", 101, retired_o,       32'd0);
        check_field("rst_hit",     101, 32'(bkpt_hit_o), 32'd0);
        tick();
        check_field("rst_stay_idle", 102, 32'(state_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run/load controller for the single-cycle core. It owns the instruction-memory write port so a host can load a program, one word per handshake. It then sequences execution by gating PC advance and register-file writes: run, single-step, halt, and one hardware breakpoint. It sits between the host/debug interface and the PC, icache and regfile of the monocycle datapath, and counts retired instructions.

Parameters:
ADDR_W, 6, icache word-address width (matches PC[7:2]).
DEPTH, 64, icache words; must equal 2**ADDR_W.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
load_start_i  in  1  begin program load (sampled in IDLE/HALT)
load_len_i  in  ADDR_W+1  words to load, legal 1..DEPTH
ld_data_i  in  32  instruction word from host
ld_valid_i  in  1  host word valid
ld_ready_o  out  1  controller accepts word
imem_we_o  out  1  icache write enable
imem_waddr_o  out  ADDR_W  icache write word address
imem_wdata_o  out  32  icache write data (= ld_data_i)
run_i  in  1  start/resume free run
step_i  in  1  execute exactly one instruction
halt_i  in  1  stop free run
bkpt_en_i  in  1  breakpoint enable
bkpt_addr_i  in  32  breakpoint byte address
pc_i  in  32  current PC from datapath
pc_en_o  out  1  PC loads pcnext this cycle
pc_rst_o  out  1  force PC to 0
regwrite_en_o  out  1  AND-gate on decoder regwrite
bkpt_hit_o  out  1  sticky: halted by breakpoint
state_o  out  3  encoded state
retired_o  out  32  retired-instruction count

Behaviour:
- Reset: state IDLE; load counter 0, retired_o 0, bkpt_hit_o 0, skip flag 0. Outputs in IDLE: pc_rst_o=1, all others 0.
- States and encoding: IDLE=0, LOAD=1, CLEAR=2, HALT=3, RUN=4, STEP=5.
- pc_en_o, regwrite_en_o, ld_ready_o and imem_we_o are combinational from state plus current inputs. Counters and state are registered.
- IDLE:
  - load_start_i with load_len_i in 1..DEPTH: latch length, clear load counter, go to LOAD.
  - Illegal length (0 or >DEPTH): ignore and stay in IDLE.
  - run_i/step_i ignored.
- LOAD:
  - ld_ready_o=1; imem_we_o = ld_valid_i; imem_waddr_o = load counter.
  - Each accepted word increments the counter.
  - Acceptance of word len-1 goes to CLEAR.
  - ld_valid_i low: wait indefinitely.
  - All other commands ignored.
- CLEAR: one cycle; pc_rst_o=1, retired_o cleared, bkpt_hit_o cleared; next state HALT.
- HALT:
  - pc_en_o=0, regwrite_en_o=0.
  - Priority load_start_i > step_i > run_i.
  - A legal load goes to LOAD; an illegal load is ignored.
  - step_i goes to STEP; run_i goes to RUN and sets the skip flag.
  - Leaving HALT clears bkpt_hit_o.
- RUN:
  - Default: pc_en_o=1, regwrite_en_o=1, retired_o+1 per cycle.
  - Breakpoint hit (bkpt_en_i, pc_i==bkpt_addr_i, skip flag 0): pc_en_o=0, regwrite_en_o=0, no increment, set bkpt_hit_o, go to HALT. The instruction at the breakpoint is not executed.
  - Skip flag is cleared after the first RUN cycle, so resuming at the breakpoint PC executes that instruction.
  - Else halt_i: the current cycle's instruction still executes and retires, then go to HALT.
  - Breakpoint has priority over halt_i.
  - load_start_i, run_i, step_i ignored.
- STEP: one cycle with pc_en_o=1, regwrite_en_o=1, retired_o+1; next state HALT; breakpoint ignored.
- retired_o wraps 0xFFFFFFFF to 0.
- Synchronous reset mid-LOAD or mid-RUN: return to IDLE next edge; partially loaded icache contents are left unchanged.

Test Plan:
1. Reset 2 cycles, then load_len_i=3 with words 0x00500093, 0x00308113, 0x002081B3, valid every cycle:
   - imem_we_o pulses at addresses 0,1,2.
   - CLEAR asserts pc_rst_o for 1 cycle; state_o=3.
2. Load with valid toggling 1,0,1,0,1, len 3:
   - Exactly 3 writes, addresses 0..2, no write on valid=0 cycles.
   - load_len_i=0 in IDLE: state stays 0.
3. From HALT, step_i three times:
   - pc_en_o high exactly 3 single cycles; retired_o=3.
   - state_o 5→3 each time.
4. bkpt_en_i=1, bkpt_addr_i=0x8, run_i with PC advancing 0,4,8:
   - Halt at PC 0x8 with pc_en_o=0 that cycle, bkpt_hit_o=1, retired_o=2.
   - run_i again: PC 0x8 executes, bkpt_hit_o=0.
5. RUN then halt_i at retired_o=5:
   - That cycle still retires (retired_o=6), then HALT.
   - halt_i and a breakpoint in the same cycle: breakpoint wins, retired_o unchanged.
6. rst_i asserted during LOAD after 1 word:
   - Next cycle state_o=0, pc_rst_o=1, ld_ready_o=0, retired_o=0.
